// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state encoding, default idle word and
// helpers that turn CPOL/CPHA into concrete rising/falling edge roles.
package spi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Word shifted out when nothing was queued; sliced to the word width by users.
    localparam logic [63:0] SPI_IDLE_WORD_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // The leading edge is the transition away from the idle level.
    function automatic logic spi_leading_is_rise(input logic cpol);
        return ~cpol;
    endfunction

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
        return cpha ? ~spi_leading_is_rise(cpol) : spi_leading_is_rise(cpol);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side handshake of the SPI responder: TX buffer write port and
// RX word / status outputs.
interface spi_slave_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 spi_en;
    logic [DATA_BITS-1:0] data_in;
    logic                 ready_out;
    logic                 valid_out;
    logic [DATA_BITS-1:0] data_out;
    logic                 underrun;

    // Responder side.
    modport slave (
        input  spi_en,
        input  data_in,
        output ready_out,
        output valid_out,
        output data_out,
        output underrun
    );

    // User logic side.
    modport master (
        output spi_en,
        output data_in,
        input  ready_out,
        input  valid_out,
        input  data_out,
        input  underrun
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by a
// previous-value stage and registered rise/fall pulses. Edges are held off
// until the pipeline has been refilled with real pin values after reset, so
// a pin that is already at its non-reset level does not look like an edge.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       rise_q,  rise_d;
    logic       fall_q,  fall_d;
    logic [1:0] fill_q,  fill_d;

    // Next-state for the synchroniser chain and edge pulses.
    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        if (fill_q == 2'd3) begin
            fill_d = fill_q;
            rise_d = sync2_q & ~prev_q;
            fall_d = ~sync2_q & prev_q;
        end else begin
            fill_d = fill_q + 2'd1;
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    // Synchroniser, compare stage and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            prev_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fill_q  <= fill_d;
        end
    end

    // Level is taken from the compare stage so it lines up with the pulses.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder. Oversamples SCK/SS/MOSI in the clk domain, deserialises
// MOSI into words with a valid pulse and serialises a one-word TX buffer
// onto MISO. An empty buffer at a word load sends IDLE_WORD and pulses
// underrun.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                   DATA_BITS = 8,
    parameter logic                 CPOL      = 1'b0,
    parameter logic                 CPHA      = 1'b0,
    parameter logic                 LSBF      = 1'b0,
    parameter logic [DATA_BITS-1:0] IDLE_WORD = SPI_IDLE_WORD_ALL_ONES[DATA_BITS-1:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCK,
    input  logic       SS,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    spi_slave_if.slave bus
);

    localparam int                CW             = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0]     LAST_BIT       = CW'(DATA_BITS - 1);
    localparam logic              SAMPLE_ON_RISE = spi_sample_on_rise(CPOL, CPHA);

    // Insert one received bit at the end opposite to the bit order.
    function automatic logic [DATA_BITS-1:0] rx_shift(input logic [DATA_BITS-1:0] sr,
                                                      input logic                 bit_in);
        logic [DATA_BITS-1:0] r;
        if (LSBF) begin
            r = {bit_in, sr[DATA_BITS-1:1]};
        end else begin
            r = {sr[DATA_BITS-2:0], bit_in};
        end
        return r;
    endfunction

    // Advance the transmit register so the next bit reaches the output end.
    function automatic logic [DATA_BITS-1:0] tx_shift(input logic [DATA_BITS-1:0] sr);
        logic [DATA_BITS-1:0] r;
        if (LSBF) begin
            r = {1'b0, sr[DATA_BITS-1:1]};
        end else begin
            r = {sr[DATA_BITS-2:0], 1'b0};
        end
        return r;
    endfunction

    // Bit currently presented on MISO for a given transmit register.
    function automatic logic tx_out_bit(input logic [DATA_BITS-1:0] sr);
        return LSBF ? sr[0] : sr[DATA_BITS-1];
    endfunction

    // Synchronised pin views.
    logic sck_rise_s, sck_fall_s, sck_level_unused;
    logic ss_rise_s,  ss_fall_s,  ss_level_unused;
    logic mosi_s,     mosi_rise_unused, mosi_fall_unused;
    logic sample_s,   shift_s,    load_s;

    spi_pin_sync #(.RESET_VAL(CPOL)) u_sync_sck (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (SCK),
        .level_o (sck_level_unused),
        .rise_o  (sck_rise_s),
        .fall_o  (sck_fall_s)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_ss (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (SS),
        .level_o (ss_level_unused),
        .rise_o  (ss_rise_s),
        .fall_o  (ss_fall_s)
    );

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (MOSI),
        .level_o (mosi_s),
        .rise_o  (mosi_rise_unused),
        .fall_o  (mosi_fall_unused)
    );

    assign sample_s = SAMPLE_ON_RISE ? sck_rise_s : sck_fall_s;
    assign shift_s  = SAMPLE_ON_RISE ? sck_fall_s : sck_rise_s;

    spi_state_e           state_q,        state_d;
    logic [CW-1:0]        bit_cnt_q,      bit_cnt_d;
    logic [DATA_BITS-1:0] rx_sr_q,        rx_sr_d;
    logic [DATA_BITS-1:0] tx_sr_q,        tx_sr_d;
    logic                 load_pending_q, load_pending_d;
    logic [DATA_BITS-1:0] data_out_q,     data_out_d;
    logic                 valid_q,        valid_d;
    logic                 underrun_q,     underrun_d;
    logic [DATA_BITS-1:0] buf_q,          buf_d;
    logic                 ready_q,        ready_d;
    logic                 miso_q,         miso_d;
    logic                 miso_oe_q,      miso_oe_d;

    // Frame FSM, shift registers, TX buffer and output next-state.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        load_pending_d = load_pending_q;
        data_out_d     = data_out_q;
        valid_d        = 1'b0;
        underrun_d     = 1'b0;
        buf_d          = buf_q;
        ready_d        = ready_q;
        load_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d      = '0;
                load_pending_d = 1'b0;
                if (ss_fall_s) begin
                    state_d = ST_ACTIVE;
                    // With CPHA=1 the first bit is driven on the first leading edge.
                    if (CPHA) begin
                        load_pending_d = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    // Abort: partial words are dropped, the TX buffer survives.
                    state_d        = ST_IDLE;
                    bit_cnt_d      = '0;
                    load_pending_d = 1'b0;
                    rx_sr_d        = '0;
                    tx_sr_d        = '0;
                end else if (sample_s) begin
                    rx_sr_d = rx_shift(rx_sr_q, mosi_s);
                    if (bit_cnt_q == LAST_BIT) begin
                        data_out_d     = rx_sr_d;
                        valid_d        = 1'b1;
                        bit_cnt_d      = '0;
                        load_pending_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (shift_s) begin
                    if (load_pending_q) begin
                        load_s         = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        tx_sr_d = tx_shift(tx_sr_q);
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                bit_cnt_d      = '0;
                load_pending_d = 1'b0;
            end
        endcase

        // Word load: take the buffer if full, otherwise the idle word.
        if (load_s) begin
            if (!ready_q) begin
                tx_sr_d = buf_q;
                ready_d = 1'b1;
            end else begin
                tx_sr_d    = IDLE_WORD;
                underrun_d = 1'b1;
            end
        end else begin
            ready_d = ready_q;
        end

        // A write is accepted only into an empty buffer; it may coincide with
        // an idle-word load and is still stored.
        if (bus.spi_en && ready_q) begin
            buf_d   = bus.data_in;
            ready_d = 1'b0;
        end else begin
            buf_d = buf_q;
        end

        miso_d    = tx_out_bit(tx_sr_d);
        miso_oe_d = (state_d == ST_ACTIVE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            rx_sr_q        <= '0;
            tx_sr_q        <= '0;
            load_pending_q <= 1'b0;
            data_out_q     <= '0;
            valid_q        <= 1'b0;
            underrun_q     <= 1'b0;
            buf_q          <= '0;
            ready_q        <= 1'b1;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_sr_q        <= rx_sr_d;
            tx_sr_q        <= tx_sr_d;
            load_pending_q <= load_pending_d;
            data_out_q     <= data_out_d;
            valid_q        <= valid_d;
            underrun_q     <= underrun_d;
            buf_q          <= buf_d;
            ready_q        <= ready_d;
            miso_q         <= miso_d;
            miso_oe_q      <= miso_oe_d;
        end
    end

    assign MISO          = miso_q;
    assign miso_oe       = miso_oe_q;
    assign bus.ready_out = ready_q;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one responder per SPI mode sharing SCK/MOSI, each with
// its own SS. A bit-banged master drives frames; received words are checked
// against a scoreboard queue filled as MOSI words are driven.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 8;   // SCK half period in clk cycles

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sck  = 1'b0;
    logic       mosi = 1'b0;
    logic [3:0] ss   = 4'hF;
    logic [3:0] en   = 4'h0;
    logic [7:0] din  = 8'h00;
    wire  [3:0] miso;
    wire  [3:0] oe;

    int   m    = 0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic lsbf = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int valid_cnt   = 0;
    int ur_cnt      = 0;
    logic [7:0] rx_q[$];

    logic       s_valid, s_ur, s_ready, s_miso, s_oe;
    logic [7:0] s_data;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_BITS(8)) b0 ();
    spi_slave_if #(.DATA_BITS(8)) b1 ();
    spi_slave_if #(.DATA_BITS(8)) b2 ();
    spi_slave_if #(.DATA_BITS(8)) b3 ();

    assign b0.spi_en = en[0];
    assign b1.spi_en = en[1];
    assign b2.spi_en = en[2];
    assign b3.spi_en = en[3];
    assign b0.data_in = din;
    assign b1.data_in = din;
    assign b2.data_in = din;
    assign b3.data_in = din;

    spi_slave #(.DATA_BITS(8), .CPOL(1'b0), .CPHA(1'b0), .LSBF(1'b0)) u0 (
        .clk(clk), .rst(rst), .SCK(sck), .SS(ss[0]), .MOSI(mosi),
        .MISO(miso[0]), .miso_oe(oe[0]), .bus(b0));
    spi_slave #(.DATA_BITS(8), .CPOL(1'b0), .CPHA(1'b1), .LSBF(1'b1)) u1 (
        .clk(clk), .rst(rst), .SCK(sck), .SS(ss[1]), .MOSI(mosi),
        .MISO(miso[1]), .miso_oe(oe[1]), .bus(b1));
    spi_slave #(.DATA_BITS(8), .CPOL(1'b1), .CPHA(1'b0), .LSBF(1'b1)) u2 (
        .clk(clk), .rst(rst), .SCK(sck), .SS(ss[2]), .MOSI(mosi),
        .MISO(miso[2]), .miso_oe(oe[2]), .bus(b2));
    spi_slave #(.DATA_BITS(8), .CPOL(1'b1), .CPHA(1'b1), .LSBF(1'b1)) u3 (
        .clk(clk), .rst(rst), .SCK(sck), .SS(ss[3]), .MOSI(mosi),
        .MISO(miso[3]), .miso_oe(oe[3]), .bus(b3));

    // View of the responder for the mode under test.
    always_comb begin
        case (m)
            1: begin s_valid = b1.valid_out; s_ur = b1.underrun; s_ready = b1.ready_out; s_data = b1.data_out; end
            2: begin s_valid = b2.valid_out; s_ur = b2.underrun; s_ready = b2.ready_out; s_data = b2.data_out; end
            3: begin s_valid = b3.valid_out; s_ur = b3.underrun; s_ready = b3.ready_out; s_data = b3.data_out; end
            default: begin s_valid = b0.valid_out; s_ur = b0.underrun; s_ready = b0.ready_out; s_data = b0.data_out; end
        endcase
        s_miso = miso[m];
        s_oe   = oe[m];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: count pulses and compare each received word.
    always @(negedge clk) begin
        if (s_valid) begin
            valid_cnt++;
            if (rx_q.size() != 0) begin
                check_val("rx_word", 32'(s_data), 32'(rx_q.pop_front()));
            end
        end
        if (s_ur) begin
            ur_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int mm);
        m    = mm;
        cpol = (mm == 2 || mm == 3);
        cpha = (mm == 1 || mm == 3);
        lsbf = (mm != 0);
        sck  = cpol;
        wait_clk(16);
    endtask

    task automatic write_buf(input logic [7:0] d);
        int t = 0;
        while (!s_ready && t < 200) begin
            wait_clk(1);
            t++;
        end
        check_val("buf_ready_wait", 32'(s_ready), 32'd1);
        din   = d;
        en[m] = 1'b1;
        wait_clk(1);
        en    = 4'h0;
    endtask

    task automatic frame_begin();
        ss[m] = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        ss[m] = 1'b1;
        wait_clk(16);
    endtask

    // Clock nbits of mo out (from bit 'first' in transfer order) and collect MISO.
    task automatic xfer(input string tag, input logic [7:0] mo, input logic [7:0] miso_exp,
                        input bit do_chk, input int first, input int nbits);
        logic [7:0] got = 8'h00;
        int idx;
        if (first == 0 && nbits == 8) begin
            rx_q.push_back(mo);
        end
        for (int i = first; i < first + nbits; i++) begin
            idx = lsbf ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[idx];
                wait_clk(HALF);
                sck = ~cpol;
                got[idx] = s_miso;
                wait_clk(HALF);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mo[idx];
                wait_clk(HALF);
                sck = cpol;
                got[idx] = s_miso;
                wait_clk(HALF);
            end
        end
        if (do_chk) begin
            check_val(tag, 32'(got), 32'(miso_exp));
        end
    endtask

    initial begin
        // Reset values
        set_mode(0);
        wait_clk(4);
        check_val("rst_data_out", 32'(s_data),  32'h00);
        check_val("rst_ready",    32'(s_ready), 32'd1);
        check_val("rst_valid",    32'(s_valid), 32'd0);
        check_val("rst_underrun", 32'(s_ur),    32'd0);
        check_val("rst_miso",     32'(s_miso),  32'd0);
        check_val("rst_oe",       32'(s_oe),    32'd0);
        rst = 1'b0;
        wait_clk(8);

        // Mode 0, MSB first: buffer 0xA5, master sends 0x3C
        write_buf(8'hA5);
        check_val("m0_ready_low", 32'(s_ready), 32'd0);
        valid_cnt = 0;
        frame_begin();
        check_val("m0_oe_active", 32'(s_oe), 32'd1);
        xfer("m0_miso", 8'h3C, 8'hA5, 1'b1, 0, 8);
        frame_end();
        check_val("m0_valid_cnt", 32'(valid_cnt), 32'd1);
        check_val("m0_data_out",  32'(s_data),    32'h3C);
        check_val("m0_ready",     32'(s_ready),   32'd1);
        check_val("m0_oe_idle",   32'(s_oe),      32'd0);

        // Modes 1..3, LSB first: buffer 0x7E, master sends 0x81
        for (int mm = 1; mm < 4; mm++) begin
            set_mode(mm);
            write_buf(8'h7E);
            valid_cnt = 0;
            frame_begin();
            xfer("mode_miso", 8'h81, 8'h7E, 1'b1, 0, 8);
            frame_end();
            check_val("mode_valid_cnt", 32'(valid_cnt), 32'd1);
            check_val("mode_data_out",  32'(s_data),    32'h81);
        end

        // Three-word frame in mode 1, buffer refilled per word
        set_mode(1);
        valid_cnt = 0;
        ur_cnt    = 0;
        write_buf(8'h11);
        frame_begin();
        xfer("w3_miso0", 8'hC1, 8'h11, 1'b1, 0, 8);
        write_buf(8'h22);
        xfer("w3_miso1", 8'hC2, 8'h22, 1'b1, 0, 8);
        write_buf(8'h33);
        xfer("w3_miso2", 8'hC3, 8'h33, 1'b1, 0, 8);
        frame_end();
        check_val("w3_valid_cnt", 32'(valid_cnt), 32'd3);
        check_val("w3_underruns", 32'(ur_cnt),    32'd0);
        check_val("w3_data_out",  32'(s_data),    32'hC3);

        // Underrun: buffer empty for a two-word frame
        valid_cnt = 0;
        ur_cnt    = 0;
        frame_begin();
        xfer("ur_miso0", 8'h5A, 8'hFF, 1'b1, 0, 8);
        xfer("ur_miso1", 8'hA5, 8'hFF, 1'b1, 0, 8);
        frame_end();
        check_val("ur_count",     32'(ur_cnt),    32'd2);
        check_val("ur_valid_cnt", 32'(valid_cnt), 32'd2);

        // Abort after 5 bits of 0xF0, then a clean 0x55 frame
        set_mode(0);
        valid_cnt = 0;
        frame_begin();
        xfer("abort_part", 8'hF0, 8'h00, 1'b0, 0, 5);
        wait_clk(HALF);
        check_val("abort_oe_before", 32'(s_oe), 32'd1);
        ss[m] = 1'b1;
        wait_clk(4);
        check_val("abort_oe_after", 32'(s_oe), 32'd0);
        wait_clk(16);
        check_val("abort_valid_cnt", 32'(valid_cnt), 32'd0);
        frame_begin();
        xfer("abort_next", 8'h55, 8'h00, 1'b0, 0, 8);
        frame_end();
        check_val("abort_next_valid", 32'(valid_cnt), 32'd1);
        check_val("abort_next_data",  32'(s_data),    32'h55);

        // Reset after 3 bits with a word waiting in the buffer
        valid_cnt = 0;
        frame_begin();
        xfer("rst_part", 8'hAA, 8'h00, 1'b0, 0, 3);
        write_buf(8'hC3);
        check_val("midrst_pre_ready", 32'(s_ready), 32'd0);
        check_val("midrst_pre_miso",  32'(s_miso),  32'd1);
        rst = 1'b1;
        wait_clk(1);
        check_val("midrst_data_out", 32'(s_data),  32'h00);
        check_val("midrst_ready",    32'(s_ready), 32'd1);
        check_val("midrst_valid",    32'(s_valid), 32'd0);
        check_val("midrst_underrun", 32'(s_ur),    32'd0);
        check_val("midrst_miso",     32'(s_miso),  32'd0);
        check_val("midrst_oe",       32'(s_oe),    32'd0);
        rst = 1'b0;
        xfer("rst_rest", 8'hAA, 8'h00, 1'b0, 3, 5);
        check_val("midrst_oe_rest", 32'(s_oe), 32'd0);
        frame_end();
        check_val("midrst_valid_cnt", 32'(valid_cnt), 32'd0);
        frame_begin();
        xfer("rst_next", 8'h96, 8'h00, 1'b0, 0, 8);
        frame_end();
        check_val("midrst_next_valid", 32'(valid_cnt), 32'd1);
        check_val("midrst_next_data",  32'(s_data),    32'h96);

        check_val("rx_pending", 32'(rx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
